ft_tx_pattern_gen: RTL and testbench
====================================

Name: ft_tx_pattern_gen

Overview:
Parametrised FT601 transmit-path test-pattern generator. It drives the write side of the TX FIFO (wr_data / wr_en / wr_full), replacing the fixed byte-ramp debug source. It adds selectable patterns, burst/gap shaping, a finite or continuous run length, abort, and status counters. It sits between board-level control (switches/VIO) and the FT601 bridge's FIFO write port, in the wr_clk domain.

Parameters:
DATA_W, 32, FIFO word width; multiple of 32, range 32..256.
CNT_W, 16, width of burst_len, gap_len and num_bursts.
LFSR_SEED, 32'h0000_0001, LFSR value loaded on every start; must be non-zero.

Ports:
wr_clk  in  1  FIFO write clock; all logic is on its rising edge.
sys_rst  in  1  asynchronous, active-high reset.
ft_ready  in  1  FT bridge ready; no writes are issued while low.
start  in  1  single-cycle pulse; latches the configuration and begins a run. Honoured only in IDLE or DONE.
abort  in  1  stops the run; wins over start.
mode  in  2  0 = byte ramp, 1 = word counter, 2 = LFSR32, 3 = walking one.
burst_len  in  CNT_W  words per burst; 0 is treated as 1.
gap_len  in  CNT_W  idle cycles between bursts; 0 means back-to-back bursts.
num_bursts  in  CNT_W  bursts per run; 0 means run until abort.
wr_full  in  1  FIFO full.
wr_data  out  DATA_W  write data.
wr_en  out  1  write strobe.
busy  out  1  high in BURST or GAP.
done  out  1  sticky run-complete flag.
word_cnt  out  32  words written in the current run; wraps at 2^32.
burst_cnt  out  CNT_W  bursts completed in the current run.

Behaviour:
- Reset values: wr_data=0, wr_en=0, busy=0, done=0, word_cnt=0, burst_cnt=0. State=IDLE, byte base=0, LFSR=LFSR_SEED.
- FSM states: IDLE, BURST, GAP, DONE.
- IDLE/DONE + start: latch mode/burst_len/gap_len/num_bursts. Clear word_cnt, burst_cnt, done, intra-burst counter and pattern state. Next state BURST.
- Configuration inputs are ignored outside a start cycle.
- wr_en = (state==BURST) & ft_ready & ~wr_full & ~abort. It is combinational. wr_data is registered and always shows the current pattern word.
- On each wr_en cycle: advance pattern, word_cnt+1, intra-burst count+1.
- Stall: while ft_ready=0 or wr_full=1, data and counters hold. There is no timeout.
- Burst end: the wr_en cycle that writes the burst_len-th word sets burst_cnt+1, then:
  - num_bursts!=0 and burst_cnt+1==num_bursts -> DONE, done=1;
  - else gap_len!=0 -> GAP;
  - else stay in BURST with the intra-burst count cleared.
- GAP: counts gap_len wr_clk cycles regardless of ft_ready/wr_full, then goes to BURST.
- abort in any state -> IDLE next edge. done stays 0. Counters hold their final values for readout.
- start with abort in the same cycle: abort wins.
- DONE holds done=1 and all counters until the next start.
- Pattern words, for lane k of N = DATA_W/8 bytes:
  - ramp: byte k = base+k mod 256; base += N per word. DATA_W=32 gives 03020100, 07060504, ...
  - counter: word_cnt value, zero-extended to DATA_W.
  - LFSR32: Fibonacci taps 32,22,2,1, shifted left with feedback into bit 0. The value is replicated DATA_W/32 times. It steps once per written word.
  - walking one: bit (word_cnt mod DATA_W) set, all others 0.
- sys_rst mid-run: immediate asynchronous return to reset values. wr_en drops in the same cycle.

Optional Feature:
FT_TXGEN_HDR_EN:
- Defined: the first word of every burst is a header {16'hA5A5, burst_cnt[15:0]} in the low 32 bits, zero in the upper bits. The header consumes one burst_len slot and counts in word_cnt. Pattern state does not advance on a header write.
- Undefined: no header logic; every word is pattern data.

Test Plan:
- DATA_W=32, mode 0, burst_len=4, gap_len=0, num_bursts=2, wr_full=0, ft_ready=1 -> 8 consecutive writes 03020100..1F1E1D1C, then done=1, word_cnt=8, burst_cnt=2.
- mode 0, 70-word burst -> word 64 equals 03020100 (ramp wraps after 64 words).
- mode 1, burst_len=3, gap_len=5, num_bursts=2 -> words 0,1,2, then 5 idle cycles with wr_en=0, then words 3,4,5, then done.
- wr_full held high for 10 cycles mid-burst -> wr_en=0 and wr_data/word_cnt frozen; resumes with the same word.
- mode 2, num_bursts=0, abort after 100 words -> first word 00000001, second 00000002; IDLE, done=0, word_cnt=100. A start issued with abort in the same cycle is ignored.
- With FT_TXGEN_HDR_EN, burst_len=2, num_bursts=2, mode 1 -> A5A50000, 00000000, A5A50001, 00000001.

Source files
------------

// File: rtl/ft_tx_pattern_gen.sv
// FT601 TX-FIFO test-pattern generator: ramp/counter/LFSR/walking-one words with burst/gap shaping.
// Optional FT_TXGEN_HDR_EN: first word of every burst is a {A5A5, burst_cnt} header.
`timescale 1ns/1ps
module ft_tx_pattern_gen #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'h0000_0001
) (
  input  logic              wr_clk,
  input  logic              sys_rst,
  input  logic              ft_ready,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic [CNT_W-1:0]  gap_len,
  input  logic [CNT_W-1:0]  num_bursts,
  input  logic              wr_full,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic              busy,
  output logic              done,
  output logic [31:0]       word_cnt,
  output logic [CNT_W-1:0]  burst_cnt
);

  localparam int unsigned NB     = DATA_W / 8;
  localparam int unsigned NW     = DATA_W / 32;
  localparam int unsigned WALK_W = $clog2(DATA_W);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_GAP, S_DONE} state_t;

  state_t              state_q, state_n;
  logic [1:0]          mode_q, mode_n;
  logic [CNT_W-1:0]    blen_q, blen_n, gap_q, gap_n, nb_q, nb_n;
  logic [CNT_W-1:0]    beat_q, beat_n, gcnt_q, gcnt_n;
  logic [CNT_W-1:0]    burst_cnt_q, burst_cnt_n, blen_last;
  logic [7:0]          base_q, base_n;
  logic [31:0]         lfsr_q, lfsr_n, pcnt_q, pcnt_n, word_cnt_q, word_cnt_n;
  logic [WALK_W-1:0]   walk_q, walk_n;
  logic                done_q, done_n, busy_q, busy_n;
  logic [DATA_W-1:0]   data_q, data_n;
  logic                adv, upd;

  function automatic logic [DATA_W-1:0] pattern_word(input logic [1:0] md, input logic [7:0] base,
      input logic [31:0] lfsr, input logic [31:0] pcnt, input logic [WALK_W-1:0] walk);
    logic [DATA_W-1:0] w;
    w = '0;
    case (md)
      2'd0:    for (int unsigned k = 0; k < NB; k++) w[k*8 +: 8] = base + 8'(k);
      2'd1:    w = DATA_W'(pcnt);
      2'd2:    for (int unsigned j = 0; j < NW; j++) w[j*32 +: 32] = lfsr;
      default: w[walk] = 1'b1;
    endcase
    return w;
  endfunction

  // XNOR feedback (taps 32,22,2,1) so a seed of 1 steps 1 -> 2 -> 4 ...
  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return {l[30:0], ~(l[31] ^ l[21] ^ l[1] ^ l[0])};
  endfunction

`ifdef FT_TXGEN_HDR_EN
  function automatic logic [DATA_W-1:0] header_word(input logic [CNT_W-1:0] bc);
    logic [DATA_W-1:0] w;
    w = '0;
    w[31:0] = {16'hA5A5, 16'(bc)};
    return w;
  endfunction
`endif

  assign wr_en     = (state_q == S_BURST) & ft_ready & ~wr_full & ~abort;
  assign blen_last = (blen_q == '0) ? '0 : blen_q - CNT_W'(1);

  // Next-state, counters and pattern update
  always_comb begin
    state_n     = state_q;
    mode_n      = mode_q;
    blen_n      = blen_q;
    gap_n       = gap_q;
    nb_n        = nb_q;
    beat_n      = beat_q;
    gcnt_n      = gcnt_q;
    burst_cnt_n = burst_cnt_q;
    base_n      = base_q;
    lfsr_n      = lfsr_q;
    pcnt_n      = pcnt_q;
    walk_n      = walk_q;
    word_cnt_n  = word_cnt_q;
    done_n      = done_q;
    data_n      = data_q;
    adv         = 1'b0;
    upd         = 1'b0;

    if (abort) begin
      state_n = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_n     = S_BURST;
            mode_n      = mode;
            blen_n      = burst_len;
            gap_n       = gap_len;
            nb_n        = num_bursts;
            beat_n      = '0;
            gcnt_n      = '0;
            burst_cnt_n = '0;
            base_n      = '0;
            lfsr_n      = LFSR_SEED;
            pcnt_n      = '0;
            walk_n      = '0;
            word_cnt_n  = '0;
            done_n      = 1'b0;
            upd         = 1'b1;
          end
        end
        S_BURST: begin
          if (wr_en) begin
            upd        = 1'b1;
`ifdef FT_TXGEN_HDR_EN
            adv        = (beat_q != '0);
`else
            adv        = 1'b1;
`endif
            word_cnt_n = word_cnt_q + 32'd1;
            if (beat_q == blen_last) begin
              beat_n      = '0;
              burst_cnt_n = burst_cnt_q + CNT_W'(1);
              if (nb_q != '0 && burst_cnt_n == nb_q) begin
                state_n = S_DONE;
                done_n  = 1'b1;
              end else if (gap_q != '0) begin
                state_n = S_GAP;
                gcnt_n  = '0;
              end
            end else begin
              beat_n = beat_q + CNT_W'(1);
            end
          end
        end
        S_GAP: begin
          if (gcnt_q == gap_q - CNT_W'(1)) state_n = S_BURST;
          else                              gcnt_n  = gcnt_q + CNT_W'(1);
        end
        default: state_n = S_IDLE;
      endcase
    end

    if (adv) begin
      base_n = base_q + 8'(NB);
      lfsr_n = lfsr_step(lfsr_q);
      pcnt_n = pcnt_q + 32'd1;
      walk_n = (walk_q == WALK_W'(DATA_W - 1)) ? '0 : walk_q + WALK_W'(1);
    end

`ifdef FT_TXGEN_HDR_EN
    if (upd) data_n = (beat_n == '0) ? header_word(burst_cnt_n)
                                     : pattern_word(mode_n, base_n, lfsr_n, pcnt_n, walk_n);
`else
    if (upd) data_n = pattern_word(mode_n, base_n, lfsr_n, pcnt_n, walk_n);
`endif

    busy_n = (state_n == S_BURST) || (state_n == S_GAP);
  end

  always_ff @(posedge wr_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      blen_q      <= '0;
      gap_q       <= '0;
      nb_q        <= '0;
      beat_q      <= '0;
      gcnt_q      <= '0;
      burst_cnt_q <= '0;
      base_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      pcnt_q      <= '0;
      walk_q      <= '0;
      word_cnt_q  <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
    end else begin
      state_q     <= state_n;
      mode_q      <= mode_n;
      blen_q      <= blen_n;
      gap_q       <= gap_n;
      nb_q        <= nb_n;
      beat_q      <= beat_n;
      gcnt_q      <= gcnt_n;
      burst_cnt_q <= burst_cnt_n;
      base_q      <= base_n;
      lfsr_q      <= lfsr_n;
      pcnt_q      <= pcnt_n;
      walk_q      <= walk_n;
      word_cnt_q  <= word_cnt_n;
      done_q      <= done_n;
      busy_q      <= busy_n;
      data_q      <= data_n;
    end
  end

  assign wr_data   = data_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign word_cnt  = word_cnt_q;
  assign burst_cnt = burst_cnt_q;

endmodule

// File: tb/tb_ft_tx_pattern_gen.sv
// Scoreboard bench for ft_tx_pattern_gen: expected words queued at start, popped on each wr_en.
`timescale 1ns/1ps
module tb_ft_tx_pattern_gen;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  logic              wr_clk = 1'b0;
  logic              sys_rst, ft_ready, start, abort, wr_full;
  logic [1:0]        mode;
  logic [CNT_W-1:0]  burst_len, gap_len, num_bursts;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en, busy, done;
  logic [31:0]       word_cnt;
  logic [CNT_W-1:0]  burst_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  int unsigned wr_cyc[$];
  int unsigned cyc = 0;
  int unsigned mon_idx = 0;

  ft_tx_pattern_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W), .LFSR_SEED(32'h0000_0001)) dut (
    .wr_clk(wr_clk), .sys_rst(sys_rst), .ft_ready(ft_ready), .start(start), .abort(abort),
    .mode(mode), .burst_len(burst_len), .gap_len(gap_len), .num_bursts(num_bursts),
    .wr_full(wr_full), .wr_data(wr_data), .wr_en(wr_en), .busy(busy), .done(done),
    .word_cnt(word_cnt), .burst_cnt(burst_cnt)
  );

  always #5 wr_clk = ~wr_clk;
  always @(posedge wr_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference word stream for one run
  task automatic push_run(input int md, input int bl, input int nb);
    logic [31:0] lf, w;
    int p, ble;
    lf = 32'h1; p = 0; w = '0;
    ble = (bl == 0) ? 1 : bl;
    for (int b = 0; b < nb; b++)
      for (int j = 0; j < ble; j++) begin
`ifdef FT_TXGEN_HDR_EN
        if (j == 0) begin exp_q.push_back({16'hA5A5, 16'(b)}); continue; end
`endif
        case (md)
          0:       for (int k = 0; k < 4; k++) w[8*k +: 8] = 8'(4*p + k);
          1:       w = 32'(p);
          2:       w = lf;
          default: w = 32'h1 << (p % 32);
        endcase
        exp_q.push_back(w);
        lf = {lf[30:0], ~(lf[31] ^ lf[21] ^ lf[1] ^ lf[0])};
        p++;
      end
  endtask

  always @(negedge wr_clk) begin
    if (wr_en === 1'b1) begin
      check("word_cnt_at_wr", word_cnt, mon_idx);
      if (exp_q.size() == 0) check("unexpected_wr", exp_q.size(), 1);
      else                   check("wr_data", wr_data, exp_q.pop_front());
      wr_cyc.push_back(cyc);
      mon_idx++;
    end
  end

  task automatic run_start(input logic [1:0] md, input int bl, input int gp, input int nb,
                           input int exp_bursts);
    push_run(md, bl, exp_bursts);
    mon_idx = 0;
    wr_cyc.delete();
    @(posedge wr_clk); #1;
    mode = md; burst_len = CNT_W'(bl); gap_len = CNT_W'(gp); num_bursts = CNT_W'(nb);
    start = 1'b1;
    @(posedge wr_clk); #1;
    start = 1'b0;
    mode = 2'($urandom); burst_len = CNT_W'($urandom);
    gap_len = CNT_W'($urandom); num_bursts = CNT_W'($urandom);
  endtask

  task automatic wait_done(input int max_cyc);
    int n = 0;
    while (done !== 1'b1 && n < max_cyc) begin @(negedge wr_clk); n++; end
    check("done_reached", done, 1);
  endtask

  task automatic wait_wc(input int target, input int max_cyc);
    int n = 0;
    while (word_cnt !== 32'(target) && n < max_cyc) begin @(posedge wr_clk); #1; n++; end
    check("word_cnt_reached", word_cnt, target);
  endtask

  initial begin
    sys_rst = 1'b1; ft_ready = 1'b1; start = 1'b0; abort = 1'b0; wr_full = 1'b0;
    mode = '0; burst_len = '0; gap_len = '0; num_bursts = '0;
    repeat (2) @(posedge wr_clk);
    #1;
    check("rst_wr_data", wr_data, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_burst_cnt", burst_cnt, 0);
    sys_rst = 1'b0;

    // Two back-to-back ramp bursts
    run_start(2'd0, 4, 0, 2, 2);
    wait_done(100);
    check("t1_word_cnt", word_cnt, 8);
    check("t1_burst_cnt", burst_cnt, 2);
    check("t1_busy", busy, 0);
    check("t1_q_empty", exp_q.size(), 0);
    check("t1_nwr", wr_cyc.size(), 8);
    if (wr_cyc.size() == 8) check("t1_span", wr_cyc[7] - wr_cyc[0], 7);

    // Ramp wraps after 64 words
    run_start(2'd0, 70, 0, 1, 1);
    wait_done(200);
    check("t2_word_cnt", word_cnt, 70);
    check("t2_q_empty", exp_q.size(), 0);

    // Counter with 5-cycle gap
    run_start(2'd1, 3, 5, 2, 2);
    wait_done(100);
    check("t3_burst_cnt", burst_cnt, 2);
    check("t3_nwr", wr_cyc.size(), 6);
    if (wr_cyc.size() == 6) begin
      check("t3_b2b", wr_cyc[1] - wr_cyc[0], 1);
      check("t3_gap", wr_cyc[3] - wr_cyc[2], 6);
    end
    check("t3_q_empty", exp_q.size(), 0);

    // burst_len 0 acts as 1
    run_start(2'd1, 0, 0, 3, 3);
    wait_done(50);
    check("t4_word_cnt", word_cnt, 3);
    check("t4_burst_cnt", burst_cnt, 3);
    check("t4_q_empty", exp_q.size(), 0);

    // Walking one wraps past bit 31
    run_start(2'd3, 36, 0, 1, 1);
    wait_done(100);
    check("t5_word_cnt", word_cnt, 36);
    check("t5_q_empty", exp_q.size(), 0);

    // Stall on wr_full then ft_ready
    run_start(2'd1, 20, 0, 1, 1);
    wait_wc(5, 100);
    wr_full = 1'b1;
    repeat (10) begin
      @(negedge wr_clk);
      check("stall_full_wr_en", wr_en, 0);
      check("stall_full_word_cnt", word_cnt, 5);
      if (exp_q.size() > 0) check("stall_full_data", wr_data, exp_q[0]);
    end
    @(posedge wr_clk); #1;
    wr_full = 1'b0; ft_ready = 1'b0;
    repeat (3) begin
      @(negedge wr_clk);
      check("stall_rdy_wr_en", wr_en, 0);
      check("stall_rdy_word_cnt", word_cnt, 5);
    end
    @(posedge wr_clk); #1;
    ft_ready = 1'b1;
    wait_done(100);
    check("t6_word_cnt", word_cnt, 20);
    check("t6_q_empty", exp_q.size(), 0);

    // Continuous LFSR, abort after 100 words
    run_start(2'd2, 7, 0, 0, 15);
    wait_wc(100, 300);
    abort = 1'b1;
    @(negedge wr_clk);
    check("abort_wr_en", wr_en, 0);
    @(posedge wr_clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_word_cnt", word_cnt, 100);
    check("abort_burst_cnt", burst_cnt, 14);
    exp_q.delete();
    start = 1'b1; abort = 1'b1;
    @(posedge wr_clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge wr_clk);
    check("start_abort_busy", busy, 0);
    check("start_abort_word_cnt", word_cnt, 100);

    // Asynchronous reset mid-run
    run_start(2'd1, 50, 0, 1, 1);
    wait_wc(3, 50);
    #3 sys_rst = 1'b1;
    #1;
    check("arst_wr_en", wr_en, 0);
    check("arst_word_cnt", word_cnt, 0);
    check("arst_busy", busy, 0);
    check("arst_wr_data", wr_data, 0);
    exp_q.delete();
    @(posedge wr_clk); #1;
    sys_rst = 1'b0;
    repeat (2) @(negedge wr_clk);
    check("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
